// File: rtl/multichannel_mixer.sv
// -----------------------------------------------------------------------------
// multichannel_mixer
//
// Sequential N-into-one audio mixer. A sample strobe accepted in IDLE captures
// every channel sample and gain into shadow registers. The block then runs one
// multiply-accumulate per clock. It emits a single saturated sample, registered
// and marked by a one-cycle dout_valid pulse. It sits between the per-voice
// envelope/filter outputs and the DAC/PDM stage.
//
// State table:
//   state | meaning
//   IDLE  | waiting for sample_strobe; outputs hold the last result
//   ACCUM | one channel product added to acc per clock, ch = channel index
//   DONE  | scale acc back to sample range, saturate, publish result
//
// Parameters:
//   DATA_BITS    width of each signed sample and of dout
//   NUM_CHANNELS number of input channels (>= 2)
//   GAIN_BITS    width of each unsigned gain, Q1.(GAIN_BITS-1), unity = 2^(GAIN_BITS-1)
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   sample_strobe start a new mix (accepted only in IDLE)
//   din           packed signed samples, channel i at [i*DATA_BITS +: DATA_BITS]
//   gain          packed unsigned gains, channel i at [i*GAIN_BITS +: GAIN_BITS]
//   dout          signed mixed sample, held until the next result
//   dout_valid    one-cycle pulse when dout updates
//   busy          high from acceptance until the dout_valid cycle
//   clip          registered with dout; set when that result was saturated
//   overrun       one-cycle pulse when a strobe arrives outside IDLE
// -----------------------------------------------------------------------------
module multichannel_mixer #(
    parameter int DATA_BITS    = 12,
    parameter int NUM_CHANNELS = 4,
    parameter int GAIN_BITS    = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sample_strobe,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] din,
    input  logic [NUM_CHANNELS*GAIN_BITS-1:0] gain,
    output logic [DATA_BITS-1:0]              dout,
    output logic                              dout_valid,
    output logic                              busy,
    output logic                              clip,
    output logic                              overrun
);

    localparam int CH_W   = $clog2(NUM_CHANNELS);
    localparam int PROD_W = DATA_BITS + GAIN_BITS + 1;
    // One extra bit per doubling of the channel count makes overflow impossible.
    localparam int ACC_W  = PROD_W + CH_W;
    localparam int TOP_W  = ACC_W - DATA_BITS + 1;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                            state;
    logic [CH_W-1:0]                   ch;
    logic signed [ACC_W-1:0]           acc;
    logic [NUM_CHANNELS*DATA_BITS-1:0] din_lat;
    logic [NUM_CHANNELS*GAIN_BITS-1:0] gain_lat;

    logic [DATA_BITS-1:0]              din_sel;
    logic [GAIN_BITS-1:0]              gain_sel;
    logic signed [PROD_W-1:0]          prod;
    logic signed [ACC_W-1:0]           prod_ext;
    logic signed [ACC_W-1:0]           scaled;
    logic [TOP_W-1:0]                  scaled_top;
    logic                              in_range;
    logic [DATA_BITS-1:0]              sat_val;
    logic [DATA_BITS-1:0]              dout_next;

    // Current channel operands come from the shadow registers, never the live inputs.
    assign din_sel  = din_lat[ch*DATA_BITS +: DATA_BITS];
    assign gain_sel = gain_lat[ch*GAIN_BITS +: GAIN_BITS];

    // Gain is zero-extended so the multiply stays signed with an unsigned gain.
    assign prod     = $signed(din_sel) * $signed({1'b0, gain_sel});
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    // Arithmetic shift removes the Q1.x fraction with floor rounding.
    assign scaled     = acc >>> (GAIN_BITS - 1);

    // The result fits the output only if all bits from the output sign bit upward agree.
    assign scaled_top = scaled[ACC_W-1:DATA_BITS-1];
    assign in_range   = (&scaled_top) | ~(|scaled_top);
    assign sat_val    = scaled[ACC_W-1] ? {1'b1, {(DATA_BITS-1){1'b0}}}
                                        : {1'b0, {(DATA_BITS-1){1'b1}}};
    assign dout_next  = in_range ? scaled[DATA_BITS-1:0] : sat_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch         <= '0;
            acc        <= '0;
            din_lat    <= '0;
            gain_lat   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            clip       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_strobe) begin
                        din_lat  <= din;
                        gain_lat <= gain;
                        acc      <= '0;
                        ch       <= '0;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + prod_ext;
                    if (sample_strobe) begin
                        overrun <= 1'b1;
                    end
                    if (ch == LAST_CH) begin
                        ch    <= '0;
                        state <= DONE;
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end
                DONE: begin
                    dout       <= dout_next;
                    clip       <= ~in_range;
                    dout_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                    if (sample_strobe) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multichannel_mixer.sv
module tb_multichannel_mixer;

    localparam int N  = 4;
    localparam int DW = 12;
    localparam int GW = 8;

    localparam int OUT_MAX = (1 << (DW - 1)) - 1;
    localparam int OUT_MIN = -(1 << (DW - 1));

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sample_strobe = 1'b0;
    logic [N*DW-1:0] din = '0;
    logic [N*GW-1:0] gain = '0;
    logic [DW-1:0]   dout;
    logic            dout_valid;
    logic            busy;
    logic            clip;
    logic            overrun;

    int n_checks = 0;
    int n_errors = 0;
    int md[N];
    int mg[N];
    int last_dout = 0;
    int last_clip = 0;

    multichannel_mixer #(
        .DATA_BITS    (DW),
        .NUM_CHANNELS (N),
        .GAIN_BITS    (GW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_strobe (sample_strobe),
        .din           (din),
        .gain          (gain),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .busy          (busy),
        .clip          (clip),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    // Reference: weighted sum, divided by unity gain with floor rounding, then clamped.
    function automatic void model(output int y, output int c);
        longint acc;
        longint unity;
        longint s;
        acc   = 0;
        unity = longint'(1) << (GW - 1);
        for (int i = 0; i < N; i++) acc += longint'(md[i]) * longint'(mg[i]);
        s = acc / unity;
        if (acc < 0 && (acc % unity) != 0) s -= 1;
        if (s > OUT_MAX) begin
            y = OUT_MAX; c = 1;
        end else if (s < OUT_MIN) begin
            y = OUT_MIN; c = 1;
        end else begin
            y = int'(s); c = 0;
        end
    endfunction

    task automatic load_inputs();
        for (int i = 0; i < N; i++) begin
            din[i*DW +: DW]  = DW'(md[i]);
            gain[i*GW +: GW] = GW'(mg[i]);
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < N; i++) begin
            din[i*DW +: DW]  = DW'($urandom);
            gain[i*GW +: GW] = GW'($urandom);
        end
    endtask

    task automatic set4(input int d0, input int d1, input int d2, input int d3,
                        input int g0, input int g1, input int g2, input int g3);
        md[0] = d0; md[1] = d1; md[2] = d2; md[3] = d3;
        mg[0] = g0; mg[1] = g1; mg[2] = g2; mg[3] = g3;
    endtask

    // Called #1 after a clock edge; returns #1 after the edge that carries dout_valid.
    task automatic run_mix(input string tag);
        int ey;
        int ec;
        model(ey, ec);
        load_inputs();
        sample_strobe = 1'b1;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        scramble_inputs();
        for (int i = 0; i <= N; i++) begin
            check({tag, ".busy"}, int'(busy), 1);
            check({tag, ".early_valid"}, int'(dout_valid), 0);
            check({tag, ".overrun"}, int'(overrun), 0);
            check({tag, ".hold_dout"}, sx(dout), last_dout);
            check({tag, ".hold_clip"}, int'(clip), last_clip);
            @(posedge clk); #1;
        end
        check({tag, ".valid"}, int'(dout_valid), 1);
        check({tag, ".busy_low"}, int'(busy), 0);
        check({tag, ".dout"}, sx(dout), ey);
        check({tag, ".clip"}, int'(clip), ec);
        last_dout = ey;
        last_clip = ec;
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check({tag, ".idle_valid"}, int'(dout_valid), 0);
            check({tag, ".idle_busy"}, int'(busy), 0);
            check({tag, ".idle_dout"}, sx(dout), last_dout);
        end
    endtask

    initial begin
        int ey;
        int ec;
        int valids;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.dout", sx(dout), 0);
        check("rst.valid", int'(dout_valid), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.clip", int'(clip), 0);
        check("rst.overrun", int'(overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set4(100, 200, -50, -250, 128, 128, 128, 128);
        run_mix("unity");

        set4(1000, 100, 2047, -3, 64, 255, 0, 128);
        run_mix("gain");
        check("gain.value", last_dout, 696);

        set4(2047, 2047, 2047, 2047, 255, 255, 255, 255);
        run_mix("sat_hi");
        set4(-2048, -2048, -2048, -2048, 255, 255, 255, 255);
        run_mix("sat_lo");
        set4(10, -3, 7, 1, 128, 128, 128, 128);
        run_mix("unclip");

        set4(-1, 0, 0, 0, 64, 0, 0, 0);
        run_mix("floor_neg");
        set4(1, 0, 0, 0, 64, 0, 0, 0);
        run_mix("floor_pos");
        idle_cycles("gap", 2);

        // Overrun: second strobe two cycles after the first, inputs changed meanwhile
        set4(300, -700, 50, 5, 200, 17, 128, 255);
        model(ey, ec);
        load_inputs();
        sample_strobe = 1'b1;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        set4(2047, 2047, 2047, 2047, 255, 255, 255, 255);
        load_inputs();
        @(posedge clk); #1;
        check("ovr.none_yet", int'(overrun), 0);
        sample_strobe = 1'b1;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        check("ovr.pulse", int'(overrun), 1);
        check("ovr.busy", int'(busy), 1);
        @(posedge clk); #1;
        check("ovr.pulse_end", int'(overrun), 0);
        @(posedge clk); #1;
        check("ovr.early_valid", int'(dout_valid), 0);
        @(posedge clk); #1;
        check("ovr.valid", int'(dout_valid), 1);
        check("ovr.dout", sx(dout), ey);
        check("ovr.clip", int'(clip), ec);
        last_dout = ey;
        last_clip = ec;
        idle_cycles("ovr.after", 8);

        // Reset mid-mix, after a saturated result so outputs are non-zero beforehand
        set4(2047, 2047, 2047, 2047, 255, 255, 255, 255);
        run_mix("pre_rst");
        set4(500, 500, 500, 500, 128, 128, 128, 128);
        load_inputs();
        sample_strobe = 1'b1;
        @(posedge clk); #1;
        sample_strobe = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst.dout", sx(dout), 0);
        check("mid_rst.clip", int'(clip), 0);
        check("mid_rst.busy", int'(busy), 0);
        check("mid_rst.valid", int'(dout_valid), 0);
        check("mid_rst.overrun", int'(overrun), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_dout = 0;
        last_clip = 0;
        valids = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (dout_valid) valids++;
        end
        check("mid_rst.no_result", valids, 0);
        set4(100, 200, 300, -400, 128, 64, 255, 10);
        run_mix("post_rst");

        // Randomized mixes, mostly back to back (strobe coincident with dout_valid)
        for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0)
                    md[i] = ($urandom_range(0, 1) == 1) ? OUT_MAX : OUT_MIN;
                else
                    md[i] = int'($urandom_range(0, 4095)) - 2048;
                mg[i] = ($urandom_range(0, 4) == 0) ? 255 : int'($urandom_range(0, 255));
            end
            run_mix("rand");
            if ($urandom_range(0, 2) == 0) idle_cycles("rand_gap", int'($urandom_range(1, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
